// File: rtl/axis_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_capture_pkg
// Purpose  : Shared types, constants and helpers for the AXI-Stream packet
//            capture endpoint (beat layout, keep popcount, LFSR constants).
// Revision : 1.0 - initial release
// ============================================================================
package axis_capture_pkg;

    // Default beat geometry used by the packaged beat type
    localparam int c_data_bytes = 8;
    localparam int c_id_width   = 1;
    localparam int c_dest_width = 1;
    localparam int c_user_width = 1;

    // Fibonacci LFSR: x^16 + x^14 + x^13 + x^11 + 1 (bits 15,13,12,10)
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    // Widest tkeep the popcount helper accepts
    localparam int c_popcnt_max = 128;

    typedef struct packed {
        logic [c_data_bytes*8-1:0] data;
        logic                      last;
        logic [c_data_bytes-1:0]   keep;
        logic [c_data_bytes-1:0]   strb;
        logic [c_id_width-1:0]     id;
        logic [c_dest_width-1:0]   dest;
        logic [c_user_width-1:0]   user;
    } beat_t;

    // Number of set bits in a (zero-extended) tkeep vector
    function automatic logic [7:0] popcount(input logic [c_popcnt_max-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < c_popcnt_max; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_capture_fifo
// Purpose  : Show-ahead synchronous FIFO holding packed capture beats. The
//            head entry is presented combinationally; pointers carry one
//            extra wrap bit to tell full from empty.
// Revision : 1.0 - initial release
// ============================================================================
module axis_capture_fifo
    import axis_capture_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[c_aw-1:0]];

    // Storage array; contents need no reset since the head is only valid when non-empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
        end
    end

    // Read/write pointers wrap naturally modulo 2*DEPTH
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_packet_capture.sv
`default_nettype none
// ============================================================================
// Module   : axis_packet_capture
// Purpose  : AXI-Stream capture endpoint. Accepts beats into a show-ahead
//            FIFO under programmable back-pressure and an external stall,
//            and reports per-packet byte length, word count and tdest.
//            Build option AXIS_PACKET_CAPTURE_RAND_BP_EN randomises the
//            back-pressure load value with a 16-bit LFSR (0..max).
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_capture
    import axis_capture_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 64,
    parameter int MTU_BYTES  = 1500,
    parameter int BP_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            areset,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [DATA_BYTES*8-1:0]         s_axis_tdata,
    input  logic [DATA_BYTES-1:0]           s_axis_tkeep,
    input  logic [DATA_BYTES-1:0]           s_axis_tstrb,
    input  logic                            s_axis_tlast,
    input  logic [ID_WIDTH-1:0]             s_axis_tid,
    input  logic [DEST_WIDTH-1:0]           s_axis_tdest,
    input  logic [USER_WIDTH-1:0]           s_axis_tuser,
    input  logic                            stall,
    input  logic [BP_WIDTH-1:0]             max_bp_latency,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [DATA_BYTES*8-1:0]         rd_data,
    output logic                            rd_last,
    output logic [DATA_BYTES-1:0]           rd_keep,
    output logic [DATA_BYTES-1:0]           rd_strb,
    output logic [ID_WIDTH-1:0]             rd_id,
    output logic [DEST_WIDTH-1:0]           rd_dest,
    output logic [USER_WIDTH-1:0]           rd_user,
    output logic                            pkt_done,
    output logic [$clog2(MTU_BYTES+1)-1:0]  pkt_blen,
    output logic [DEST_WIDTH-1:0]           pkt_dest,
    output logic [$clog2(MTU_BYTES+1)-1:0]  pkt_words,
    output logic [31:0]                     pkt_count,
    output logic                            overflow
);

    localparam int c_len_w = $clog2(MTU_BYTES+1);
    localparam int c_sum_w = c_len_w + 9;

    // Beat layout sized by this instance's parameters
    typedef struct packed {
        logic [DATA_BYTES*8-1:0] data;
        logic                    last;
        logic [DATA_BYTES-1:0]   keep;
        logic [DATA_BYTES-1:0]   strb;
        logic [ID_WIDTH-1:0]     id;
        logic [DEST_WIDTH-1:0]   dest;
        logic [USER_WIDTH-1:0]   user;
    } cap_beat_t;

    cap_beat_t           w_beat_in;
    cap_beat_t           w_beat_out;
    cap_beat_t           w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_accept;
    logic [BP_WIDTH-1:0] r_bp_cnt;
    logic [BP_WIDTH-1:0] w_bp_load;
    logic [c_len_w-1:0]  r_words;
    logic [c_len_w-1:0]  r_bytes;
    logic [c_len_w-1:0]  w_words_nxt;
    logic [c_len_w-1:0]  w_bytes_nxt;
    logic [c_sum_w-1:0]  w_beat_bytes;
    logic [c_sum_w-1:0]  w_byte_sum;
    logic                w_over;
    logic                r_pkt_done;
    logic [c_len_w-1:0]  r_pkt_blen;
    logic [c_len_w-1:0]  r_pkt_words;
    logic [DEST_WIDTH-1:0] r_pkt_dest;
    logic [31:0]         r_pkt_count;
    logic                r_overflow;

    assign s_axis_tready = !stall && !w_full && (r_bp_cnt == '0);
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    assign w_beat_in = '{data: s_axis_tdata, last: s_axis_tlast, keep: s_axis_tkeep,
                         strb: s_axis_tstrb, id: s_axis_tid, dest: s_axis_tdest,
                         user: s_axis_tuser};

    axis_capture_fifo #(
        .WIDTH ($bits(cap_beat_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .areset    (areset),
        .i_wr_en   (w_accept),
        .i_wr_data (w_beat_in),
        .i_rd_en   (rd_ready),
        .o_rd_data (w_beat_out),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    // Head fields read as zero while the FIFO is empty
    assign w_head   = w_empty ? '0 : w_beat_out;
    assign rd_valid = !w_empty;
    assign rd_data  = w_head.data;
    assign rd_last  = w_head.last;
    assign rd_keep  = w_head.keep;
    assign rd_strb  = w_head.strb;
    assign rd_id    = w_head.id;
    assign rd_dest  = w_head.dest;
    assign rd_user  = w_head.user;

`ifdef AXIS_PACKET_CAPTURE_RAND_BP_EN
    logic [15:0] r_lfsr;

    assign w_bp_load = BP_WIDTH'(32'(r_lfsr) % (32'(max_bp_latency) + 32'd1));

    // LFSR steps once per accepted beat so each beat gets a fresh gap
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_lfsr <= c_lfsr_seed;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & c_lfsr_taps)};
        end
    end
`else
    assign w_bp_load = max_bp_latency;
`endif

    // Back-pressure counter: load on acceptance, then count idle cycles down to 0
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_bp_cnt <= '0;
        end else if (w_accept) begin
            r_bp_cnt <= w_bp_load;
        end else if (r_bp_cnt != '0) begin
            r_bp_cnt <= r_bp_cnt - BP_WIDTH'(1);
        end
    end

    // Non-last beats always count as full width; the last beat counts its tkeep
    assign w_beat_bytes = s_axis_tlast ? c_sum_w'(popcount(c_popcnt_max'(s_axis_tkeep)))
                                       : c_sum_w'(DATA_BYTES);
    assign w_byte_sum   = c_sum_w'(r_bytes) + w_beat_bytes;
    assign w_over       = (w_byte_sum > c_sum_w'(MTU_BYTES));
    assign w_bytes_nxt  = w_over ? c_len_w'(MTU_BYTES) : w_byte_sum[c_len_w-1:0];
    assign w_words_nxt  = (&r_words) ? r_words : r_words + c_len_w'(1);

    // Packet accounting: accumulate per beat, publish and clear on the last beat
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_words     <= '0;
            r_bytes     <= '0;
            r_pkt_done  <= 1'b0;
            r_pkt_blen  <= '0;
            r_pkt_words <= '0;
            r_pkt_dest  <= '0;
            r_pkt_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            if (w_accept) begin
                if (w_over) r_overflow <= 1'b1;
                if (s_axis_tlast) begin
                    r_pkt_done  <= 1'b1;
                    r_pkt_words <= w_words_nxt;
                    r_pkt_blen  <= w_bytes_nxt;
                    r_pkt_dest  <= s_axis_tdest;
                    r_pkt_count <= r_pkt_count + 32'd1;
                    r_words     <= '0;
                    r_bytes     <= '0;
                end else begin
                    r_words <= w_words_nxt;
                    r_bytes <= w_bytes_nxt;
                end
            end
        end
    end

    assign pkt_done  = r_pkt_done;
    assign pkt_blen  = r_pkt_blen;
    assign pkt_words = r_pkt_words;
    assign pkt_dest  = r_pkt_dest;
    assign pkt_count = r_pkt_count;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_packet_capture
// Purpose  : Directed self-checking bench for axis_packet_capture
//            (DATA_BYTES=8, DEPTH=64, DEST_WIDTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_packet_capture;

    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        areset;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic [7:0]  s_axis_tstrb;
    logic        s_axis_tlast;
    logic [0:0]  s_axis_tid;
    logic [1:0]  s_axis_tdest;
    logic [0:0]  s_axis_tuser;
    logic        stall;
    logic [15:0] max_bp_latency;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;
    logic        rd_last;
    logic [7:0]  rd_keep;
    logic [7:0]  rd_strb;
    logic [0:0]  rd_id;
    logic [1:0]  rd_dest;
    logic [0:0]  rd_user;
    logic        pkt_done;
    logic [10:0] pkt_blen;
    logic [1:0]  pkt_dest;
    logic [10:0] pkt_words;
    logic [31:0] pkt_count;
    logic        overflow;

    axis_packet_capture #(
        .DATA_BYTES (DB),
        .DEST_WIDTH (2)
    ) dut (
        .clk            (clk),
        .areset         (areset),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tstrb   (s_axis_tstrb),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tid     (s_axis_tid),
        .s_axis_tdest   (s_axis_tdest),
        .s_axis_tuser   (s_axis_tuser),
        .stall          (stall),
        .max_bp_latency (max_bp_latency),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .rd_last        (rd_last),
        .rd_keep        (rd_keep),
        .rd_strb        (rd_strb),
        .rd_id          (rd_id),
        .rd_dest        (rd_dest),
        .rd_user        (rd_user),
        .pkt_done       (pkt_done),
        .pkt_blen       (pkt_blen),
        .pkt_dest       (pkt_dest),
        .pkt_words      (pkt_words),
        .pkt_count      (pkt_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observers: completion pulses and popped FIFO data
    int          done_cnt = 0;
    logic [10:0] done_blen_q[$];
    logic [63:0] pop_q[$];

    always @(posedge clk) begin
        if (pkt_done === 1'b1) begin
            done_cnt++;
            done_blen_q.push_back(pkt_blen);
        end
        if (rd_valid === 1'b1 && rd_ready === 1'b1) pop_q.push_back(rd_data);
    end

    // Present one beat from a falling edge and hold it until accepted; returns
    // on the falling edge after the accepting rising edge, tvalid left high.
    task automatic send(input logic [63:0] d, input logic l, input logic [7:0] k,
                        input logic [1:0] dst, output int waited);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tkeep  = k;
        s_axis_tstrb  = k;
        s_axis_tdest  = dst;
        waited = 0;
        forever begin
            #1;
            if (s_axis_tready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
            waited++;
            if (waited > 300) begin
                check("send_timeout", 64'(waited), 64'd0);
                break;
            end
        end
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (!rd_valid) break;
            @(negedge clk);
        end
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        areset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        int w0, w1, w2, w3;
        int idx;
        int d0;
        int q0, b0;
        s_axis_tvalid  = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tkeep   = '0;
        s_axis_tstrb   = '0;
        s_axis_tlast   = 1'b0;
        s_axis_tid     = '0;
        s_axis_tdest   = '0;
        s_axis_tuser   = '0;
        stall          = 1'b0;
        max_bp_latency = '0;
        rd_ready       = 1'b0;
        areset         = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_rd_valid",  64'(rd_valid),  64'd0);
        check("rst_pkt_done",  64'(pkt_done),  64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_pkt_blen",  64'(pkt_blen),  64'd0);
        check("rst_pkt_words", 64'(pkt_words), 64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        check("rst_rd_data",   rd_data,        64'd0);
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);

        // ---- 1: three-beat packet, zero latency, final keep 0x0F ----
        send(64'h1111, 1'b0, 8'hFF, 2'd2, w); check("t1_wait0", 64'(w), 64'd0);
        send(64'h2222, 1'b0, 8'hFF, 2'd2, w); check("t1_wait1", 64'(w), 64'd0);
        send(64'h3333, 1'b1, 8'h0F, 2'd2, w); check("t1_wait2", 64'(w), 64'd0);
        s_axis_tvalid = 1'b0;
        check("t1_done",  64'(pkt_done),  64'd1);
        check("t1_blen",  64'(pkt_blen),  64'd20);
        check("t1_words", 64'(pkt_words), 64'd3);
        check("t1_dest",  64'(pkt_dest),  64'd2);
        check("t1_count", 64'(pkt_count), 64'd1);
        @(negedge clk);
        check("t1_done_pulse", 64'(pkt_done), 64'd0);
        check("t1_blen_hold",  64'(pkt_blen), 64'd20);
        rd_ready = 1'b1;
        check("t1_rd0_valid", 64'(rd_valid), 64'd1);
        check("t1_rd0_data",  rd_data,       64'h1111);
        check("t1_rd0_last",  64'(rd_last),  64'd0);
        @(negedge clk);
        check("t1_rd1_data",  rd_data,       64'h2222);
        check("t1_rd1_last",  64'(rd_last),  64'd0);
        @(negedge clk);
        check("t1_rd2_data",  rd_data,       64'h3333);
        check("t1_rd2_last",  64'(rd_last),  64'd1);
        check("t1_rd2_keep",  64'(rd_keep),  64'h0F);
        check("t1_rd2_dest",  64'(rd_dest),  64'd2);
        @(negedge clk);
        rd_ready = 1'b0;
        check("t1_empty", 64'(rd_valid), 64'd0);

`ifndef AXIS_PACKET_CAPTURE_RAND_BP_EN
        // ---- 2: latency 3 gives one acceptance every 4 cycles ----
        do_reset();
        max_bp_latency = 16'd3;
        rd_ready = 1'b1;
        send(64'hA0, 1'b0, 8'hFF, 2'd0, w0);
        send(64'hA1, 1'b0, 8'hFF, 2'd0, w1);
        send(64'hA2, 1'b0, 8'hFF, 2'd0, w2);
        send(64'hA3, 1'b1, 8'hFF, 2'd0, w3);
        s_axis_tvalid = 1'b0;
        check("t2_wait0", 64'(w0), 64'd0);
        check("t2_wait1", 64'(w1), 64'd3);
        check("t2_wait2", 64'(w2), 64'd3);
        check("t2_wait3", 64'(w3), 64'd3);
        check("t2_blen",  64'(pkt_blen),  64'd32);
        check("t2_words", 64'(pkt_words), 64'd4);
        max_bp_latency = 16'd0;
        drain();
`endif

        // ---- 3: stall, then fill to DEPTH, then one more after a pop ----
        do_reset();
        rd_ready      = 1'b0;
        stall         = 1'b1;
        idx           = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = 8'hFF;
        s_axis_tstrb  = 8'hFF;
        s_axis_tdest  = 2'd0;
        s_axis_tdata  = 64'(idx);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (s_axis_tready) idx++;
            @(negedge clk);
            s_axis_tdata = 64'(idx);
        end
        check("t3_stalled", 64'(idx), 64'd0);
        stall = 1'b0;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (s_axis_tready) idx++;
            @(negedge clk);
            s_axis_tdata = 64'(idx);
        end
        #1;
        check("t3_fill",      64'(idx),           64'd64);
        check("t3_full_rdy",  64'(s_axis_tready), 64'd0);
        check("t3_head",      rd_data,            64'd0);
        @(negedge clk);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (s_axis_tready) idx++;
            @(negedge clk);
            s_axis_tdata = 64'(idx);
        end
        #1;
        check("t3_one_more",  64'(idx),           64'd65);
        check("t3_refull",    64'(s_axis_tready), 64'd0);
        check("t3_head2",     rd_data,            64'd1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;

        // ---- 4: reset mid-packet discards everything ----
        do_reset();
        send(64'hD0, 1'b0, 8'hFF, 2'd1, w);
        send(64'hD1, 1'b0, 8'hFF, 2'd1, w);
        s_axis_tvalid = 1'b0;
        d0 = done_cnt;
        areset = 1'b1;
        #1;
        check("t4_empty", 64'(rd_valid),  64'd0);
        check("t4_count", 64'(pkt_count), 64'd0);
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_no_done", 64'(done_cnt - d0), 64'd0);
        send(64'hAB, 1'b1, 8'hFF, 2'd1, w);
        s_axis_tvalid = 1'b0;
        check("t4_done",  64'(pkt_done),  64'd1);
        check("t4_blen",  64'(pkt_blen),  64'd8);
        check("t4_words", 64'(pkt_words), 64'd1);
        check("t4_dest",  64'(pkt_dest),  64'd1);
        check("t4_count", 64'(pkt_count), 64'd1);
        check("t4_data",  rd_data,        64'hAB);

        // ---- 5: back-to-back packets with simultaneous pops ----
        do_reset();
        rd_ready = 1'b1;
        q0 = pop_q.size();
        b0 = done_blen_q.size();
        d0 = done_cnt;
        send(64'h5A, 1'b1, 8'h03, 2'd0, w);
        send(64'hB1, 1'b0, 8'hFF, 2'd1, w);
        send(64'hB2, 1'b1, 8'h01, 2'd1, w);
        s_axis_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        rd_ready = 1'b0;
        check("t5_pulses", 64'(done_cnt - d0), 64'd2);
        check("t5_count",  64'(pkt_count),     64'd2);
        check("t5_words",  64'(pkt_words),     64'd2);
        check("t5_dest",   64'(pkt_dest),      64'd1);
        check("t5_empty",  64'(rd_valid),      64'd0);
        check("t5_npkt",   64'(done_blen_q.size() - b0), 64'd2);
        if (done_blen_q.size() >= b0 + 2) begin
            check("t5_blen0", 64'(done_blen_q[b0]),     64'd2);
            check("t5_blen1", 64'(done_blen_q[b0 + 1]), 64'd9);
        end
        check("t5_npop", 64'(pop_q.size() - q0), 64'd3);
        if (pop_q.size() >= q0 + 3) begin
            check("t5_pop0", pop_q[q0],     64'h5A);
            check("t5_pop1", pop_q[q0 + 1], 64'hB1);
            check("t5_pop2", pop_q[q0 + 2], 64'hB2);
        end

        // ---- keep==0 last beat, then an over-MTU packet ----
        do_reset();
        rd_ready = 1'b1;
        send(64'h0, 1'b1, 8'h00, 2'd3, w);
        s_axis_tvalid = 1'b0;
        check("k0_blen",  64'(pkt_blen),  64'd0);
        check("k0_words", 64'(pkt_words), 64'd1);
        check("k0_dest",  64'(pkt_dest),  64'd3);
        check("ov_clear", 64'(overflow),  64'd0);
        for (int i = 0; i < 189; i++) send(64'(i), 1'b0, 8'hFF, 2'd0, w);
        send(64'hEE, 1'b1, 8'hFF, 2'd0, w);
        s_axis_tvalid = 1'b0;
        check("ov_done",  64'(pkt_done),  64'd1);
        check("ov_flag",  64'(overflow),  64'd1);
        check("ov_blen",  64'(pkt_blen),  64'd1500);
        check("ov_count", 64'(pkt_count), 64'd2);
        drain();

`ifdef AXIS_PACKET_CAPTURE_RAND_BP_EN
        // ---- 6: pseudo-random gaps stay within 1..max+1 and vary ----
        begin
            int   bad;
            logic [7:0] seen;
            do_reset();
            max_bp_latency = 16'd5;
            rd_ready = 1'b1;
            bad  = 0;
            seen = '0;
            for (int i = 0; i < 200; i++) begin
                send(64'(i), (i == 199), 8'hFF, 2'd0, w);
                if (i > 0) begin
                    if (w + 1 < 1 || w + 1 > 6) bad++;
                    else seen[w + 1] = 1'b1;
                end
            end
            s_axis_tvalid = 1'b0;
            check("t6_gap_range",    64'(bad),                    64'd0);
            check("t6_gap_variety",  64'($countones(seen) >= 2),  64'd1);
            max_bp_latency = 16'd0;
            drain();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_packet_capture.md
Name: axis_packet_capture

Overview:
- AXI-Stream slave that terminates a packet stream and stores each accepted beat in an internal show-ahead FIFO.
- The beat carries data, last, keep, strb, id, dest and user. A downstream reader pops beats one at a time.
- Reports per-packet completion: byte length, destination and word count.
- Applies programmable back-pressure and an external stall. Used as the capture endpoint behind packet routers and muxes.

Parameters:
- DATA_BYTES, 8: tdata width in bytes; must be greater than 0.
- ID_WIDTH, 1: tid width.
- DEST_WIDTH, 1: tdest width.
- USER_WIDTH, 1: tuser width.
- DEPTH, 64: FIFO depth in beats; must be a power of 2 and at least 2.
- MTU_BYTES, 1500: maximum packet length in bytes; sizes the length counters.
- BP_WIDTH, 16: width of the back-pressure latency input.

Ports:
- clk  in  1  single clock.
- areset  in  1  asynchronous reset, active-high.
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tdata  in  DATA_BYTES*8
- s_axis_tkeep  in  DATA_BYTES
- s_axis_tstrb  in  DATA_BYTES
- s_axis_tlast  in  1
- s_axis_tid  in  ID_WIDTH
- s_axis_tdest  in  DEST_WIDTH
- s_axis_tuser  in  USER_WIDTH
- stall  in  1  level; forces tready low.
- max_bp_latency  in  BP_WIDTH  idle cycles inserted after each accepted beat.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  pop the FIFO head.
- rd_data, rd_last, rd_keep, rd_strb, rd_id, rd_dest, rd_user  out  matching widths  FIFO head fields.
- pkt_done  out  1  one-cycle pulse per completed packet.
- pkt_blen  out  clog2(MTU_BYTES+1)  byte length of the completed packet.
- pkt_dest  out  DEST_WIDTH  tdest of the last beat.
- pkt_words  out  clog2(MTU_BYTES+1)  beat count of the completed packet.
- pkt_count  out  32  packets completed since reset.
- overflow  out  1  sticky; packet exceeded MTU_BYTES.

Behaviour:
- Reset values:
  - All outputs 0; FIFO empty; back-pressure counter 0; word and byte accumulators 0.
  - Reset mid-packet discards any partial packet and all FIFO contents.
- Ready:
  - s_axis_tready = !stall && !full && bp_cnt==0. This is combinational from registered state plus stall.
  - A beat is accepted when tvalid && tready.
- Back-pressure:
  - On each accepted beat, bp_cnt loads the latency value, then decrements once per cycle down to 0.
  - With latency 0, tready can stay high every cycle.
  - A max_bp_latency change takes effect at the next load.
- FIFO:
  - Show-ahead: an accepted beat is visible on rd_* on the next cycle.
  - A pop occurs when rd_valid && rd_ready.
  - A simultaneous push and pop while full is not possible, because tready is low when full.
  - A simultaneous push and pop while non-full keeps the occupancy unchanged.
  - Pointers wrap modulo DEPTH. A full/empty distinction bit is required.
- Packet accounting:
  - Each accepted beat increments the word accumulator.
  - On the accepted tlast beat, the cycle after acceptance asserts pkt_done for 1 cycle. It presents:
    - pkt_words = words;
    - pkt_blen = (words-1)*DATA_BYTES + popcount(tkeep of the last beat);
    - pkt_dest = tdest of the last beat.
  - pkt_count increments in the same cycle as pkt_done.
  - Non-last tkeep is treated as all-ones.
  - A last beat with tkeep == 0 gives pkt_blen = (words-1)*DATA_BYTES.
- Overflow: if the accumulated byte length would exceed MTU_BYTES:
  - set overflow;
  - saturate the accumulators;
  - still report completion at tlast.
- Interleaved tdest values are not tracked separately; accounting is per arrival order.
- stall asserted mid-packet only pauses acceptance; the packet continues when stall deasserts.
- pkt_blen and pkt_words hold their value until the next pkt_done.

Optional Feature:
- AXIS_PACKET_CAPTURE_RAND_BP_EN defined:
  - The back-pressure load value is a 16-bit Fibonacci LFSR output modulo (max_bp_latency+1), giving a pseudo-random value in 0..max.
  - LFSR taps 16,14,13,11; seed 16'hACE1 at reset; the LFSR advances every accepted beat.
- Undefined: the load value is exactly max_bp_latency.

Decomposition:
- Shared package axis_capture_pkg holds:
  - popcount function for tkeep;
  - LFSR seed and tap constants;
  - a beat struct typedef (data, last, keep, strb, id, dest, user) parameterized through localparams.
- One sub-module, axis_capture_fifo: a show-ahead synchronous FIFO storing the packed beat struct. The top level holds ready, back-pressure and accounting logic.

Test Plan:
1. DATA_BYTES=8, latency 0, one 3-beat packet with tdest=2 and final tkeep=8'h0F -> tready held high; pkt_done 1 cycle after the last beat; pkt_blen=20, pkt_words=3, pkt_dest=2; rd_* replays 3 beats, rd_last on the third.
2. max_bp_latency=3, feature macro undefined, continuous tvalid -> accepted beats exactly 4 cycles apart.
3. stall high with rd_ready=0 and 70 beats offered with DEPTH=64 -> no acceptance while stall is high. After stall release, exactly 64 accepted, then tready low until the first pop, then 1 more accepted.
4. areset asserted after 2 of 5 beats -> FIFO empty, pkt_count=0, no pkt_done. A following 1-beat packet with tkeep=8'hFF gives pkt_blen=8.
5. Back-to-back packets of 1 and 2 beats with simultaneous pops -> two pkt_done pulses, pkt_count=2, FIFO order preserved.
6. Feature macro defined, max_bp_latency=5, 200 beats -> every gap between accepted beats is in 1..6 cycles, and at least two different gap lengths occur.
